// File: rtl/riscv_pkg.sv
// Shared types and constants for the register-file writeback slice.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  // One buffered long-latency result: destination plus data.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  // A register is hazardous when it is not x0 and a long-latency write to it is in flight.
  function automatic logic reg_hazard(input logic [REG_ADDR_W-1:0] r,
                                      input logic [31:0]           busy);
    logic hit;
    hit = 1'b0;
    if (r != ZERO_REG) begin
      hit = busy[r];
    end else begin
      hit = 1'b0;
    end
    return hit;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO buffering long-latency writeback entries.
// Push is ignored when full and pop is ignored when empty; both may happen in one cycle.
module wb_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output wb_entry_t dout,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == {CNT_W{1'b0}});
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign dout      = r_mem[r_rd_ptr];

  // Storage array: written on accepted pushes only, contents need no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/regs_writeback.sv
// Register-file write port driver: merges ALU and long-latency results,
// tracks pending long-latency destinations and stalls decode on hazards.
module regs_writeback #(
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             alu_valid,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]                  alu_data,
  input  logic                             issue_valid,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] issue_rd,
  input  logic                             lsu_valid,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]                  lsu_data,
  output logic                             lsu_ready,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] dec_rs1,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] dec_rs2,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] dec_rd,
  output logic                             stall,
  output logic                             write_reg_enable,
  output logic [riscv_pkg::REG_ADDR_W-1:0] rd_addr,
  output logic [XLEN-1:0]                  writ_data,
  output logic                             overflow_err
);

  import riscv_pkg::*;

  logic      w_full;
  logic      w_empty;
  logic      w_push;
  logic      w_pop;
  wb_entry_t w_din;
  wb_entry_t w_head;
  logic [31:0] w_busy_next;

  logic                  r_we;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_data;
  logic                  r_from_ll;
  logic [31:0]           r_busy;
  logic                  r_ovf;

  // Long-latency results always go through the buffer; ALU wins the write port.
  assign w_push     = lsu_valid & ~w_full;
  assign w_pop      = ~alu_valid & ~w_empty;
  assign w_din.rd   = lsu_rd;
  assign w_din.data = lsu_data;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  assign lsu_ready        = ~w_full;
  assign write_reg_enable = r_we;
  assign rd_addr          = r_rd;
  assign writ_data        = r_data;
  assign overflow_err     = r_ovf;
  assign stall            = reg_hazard(dec_rs1, r_busy) |
                            reg_hazard(dec_rs2, r_busy) |
                            reg_hazard(dec_rd,  r_busy);

  // Write port arbitration: ALU first, then FIFO head; x0 results are consumed silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we      <= 1'b0;
      r_rd      <= ZERO_REG;
      r_data    <= {XLEN{1'b0}};
      r_from_ll <= 1'b0;
    end else if (alu_valid) begin
      r_we      <= (alu_rd != ZERO_REG);
      r_rd      <= alu_rd;
      r_data    <= alu_data;
      r_from_ll <= 1'b0;
    end else if (!w_empty) begin
      r_we      <= (w_head.rd != ZERO_REG);
      r_rd      <= w_head.rd;
      r_data    <= w_head.data;
      r_from_ll <= 1'b1;
    end else begin
      r_we      <= 1'b0;
      r_rd      <= r_rd;
      r_data    <= r_data;
      r_from_ll <= 1'b0;
    end
  end

  // Next scoreboard: clear on a committing long-latency write, then set on issue so set wins.
  always_comb begin
    w_busy_next = r_busy;
    if (r_we && r_from_ll) begin
      w_busy_next[r_rd] = 1'b0;
    end else begin
      w_busy_next = w_busy_next;
    end
    if (issue_valid && (issue_rd != ZERO_REG)) begin
      w_busy_next[issue_rd] = 1'b1;
    end else begin
      w_busy_next = w_busy_next;
    end
  end

  // Scoreboard register holding the pending long-latency destinations.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  // Sticky overflow flag: a result offered while the buffer is full is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (lsu_valid && w_full) begin
      r_ovf <= 1'b1;
    end else begin
      r_ovf <= r_ovf;
    end
  end

endmodule

// File: doc/regs_writeback.md
Name: regs_writeback

Overview:
- Writer side of the 32x32 register file's write port (write_reg_enable / rd_addr / writ_data).
- Merges two result sources:
  - the single-cycle ALU path;
  - a long-latency path (loads, multi-cycle mul/div).
- Buffers long-latency results in a small FIFO and keeps a busy scoreboard of pending destinations.
- Raises stall to decode on RAW/WAW hazards against in-flight long-latency writes.

Parameters:
- XLEN, 32, data width.
- FIFO_DEPTH, 2, long-latency result buffer entries (power of 2, >=2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- alu_valid  in  1  ALU result valid this cycle.
- alu_rd  in  5  ALU destination.
- alu_data  in  XLEN  ALU result.
- issue_valid  in  1  long-latency op issued this cycle; reserves issue_rd.
- issue_rd  in  5  destination of issued long-latency op.
- lsu_valid  in  1  long-latency result valid.
- lsu_rd  in  5  its destination.
- lsu_data  in  XLEN  its data.
- lsu_ready  out  1  FIFO can accept (not full).
- dec_rs1  in  5  decode-stage source 1.
- dec_rs2  in  5  decode-stage source 2.
- dec_rd  in  5  decode-stage destination.
- stall  out  1  hold decode.
- write_reg_enable  out  1  register file write enable.
- rd_addr  out  5  register file write address.
- writ_data  out  XLEN  register file write data.
- overflow_err  out  1  sticky: lsu_valid seen while lsu_ready=0.

Behaviour:
- Reset (sync, rst=1 at rising clk): write_reg_enable=0, rd_addr=0, writ_data=0, FIFO empty (lsu_ready=1), busy[31:0]=0, overflow_err=0. Reset mid-operation discards buffered results and all reservations.
- Write port outputs are registered.
  - ALU latency: alu_valid in cycle N -> write_reg_enable=1 in cycle N+1.
- Long-latency results are always enqueued, never bypassed.
  - lsu_valid && lsu_ready in cycle N -> entry at FIFO head in N+1.
  - Earliest write_reg_enable is cycle N+2.
- Arbitration each cycle; ALU has strict priority:
  - alu_valid=1: output regs load the ALU result; FIFO does not pop.
  - alu_valid=0 and FIFO non-empty: head loads into output regs; FIFO pops.
  - Neither: write_reg_enable=0 next cycle. rd_addr/writ_data hold their values.
- x0 handling: a selected result with rd=0 is consumed (FIFO still pops) but produces write_reg_enable=0. No output ever writes x0.
- FIFO:
  - lsu_ready = !full.
  - Push and pop in the same cycle are both performed.
  - Push while full is ignored and sets overflow_err (cleared only by rst).
  - Pointers wrap modulo FIFO_DEPTH.
- Scoreboard:
  - issue_valid && issue_rd!=0 sets busy[issue_rd].
  - A committed long-latency write clears busy[rd_addr] on the edge ending that cycle; the register file captures data on the same edge.
  - ALU writes never touch busy.
  - Same register set and cleared on the same edge: set wins.
- stall (combinational) = hazard(dec_rs1) | hazard(dec_rs2) | hazard(dec_rd), where hazard(r) = (r!=0) & busy[r].
  - Deasserts in the cycle after the clearing write; the register file read then returns the new value.
- Upstream obligations:
  - Never present issue_valid or alu_valid for a decode held by stall.
  - Each issued long-latency op returns exactly one lsu result.

Decomposition:
- Shared package riscv_pkg:
  - XLEN, REG_ADDR_W=5, ZERO_REG=5'd0.
  - typedef wb_entry_t {rd[4:0], data[XLEN-1:0]}.
- One sub-module, wb_fifo: synchronous FIFO of wb_entry_t.
  - Ports: clk, rst, push, pop, din, dout, full, empty.
  - The top owns arbitration, scoreboard, stall and the error flag.

Test Plan:
- ALU write: alu_valid=1, alu_rd=5, alu_data=0x12345678 at N -> N+1 write_reg_enable=1, rd_addr=5, writ_data=0x12345678; N+2 write_reg_enable=0.
- Load RAW: issue_valid, issue_rd=7 at N; dec_rs1=7 from N+1 -> stall=1. lsu_valid rd=7 data=0xDEADBEEF at N+3 -> write at N+5 -> stall=0 at N+6.
- Priority collision:
  - Stimulus: FIFO holds {rd=3, 0xAA}; alu_valid {rd=4, 0xBB} for 2 consecutive cycles.
  - Response: two writes of rd=4, then rd=3=0xAA, in that order.
- Full/overflow (FIFO_DEPTH=2): 2 lsu pushes during 3 consecutive alu_valid cycles -> lsu_ready=0. A 3rd lsu_valid -> overflow_err=1 and is dropped; exactly 2 lsu writes follow.
- x0 and same-cycle set/clear:
  - lsu result rd=0 -> consumed, no write_reg_enable.
  - Commit of rd=9 on the same edge as issue_valid rd=9 -> busy[9] remains 1, stall with dec_rs2=9.
- Reset mid-operation: rst=1 while FIFO holds 1 entry and busy[9]=1 -> next cycle lsu_ready=1, stall=0, write_reg_enable=0, overflow_err=0.
